mem_stage: RTL and testbench

Memory stage of the 5-stage MIPS datapath, fed directly by the EX/MEM pipeline register. It contains the word-organised data memory with byte, halfword and word access, and resolves branch and jump-register redirects toward IF. It also holds the MEM/WB pipeline register that feeds the write-back mux and register file.

---
 rtl/mem_stage.sv | 141 ++++++++++++++
 tb/tb_mem_stage.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// MIPS memory stage: byte/halfword/word data memory, branch/jr redirect, MEM/WB register.
// Optional build macro MEM_MISALIGN_TRAP_EN adds misaligned-access suppression and a sticky Misalign_out.
module mem_stage #(
  parameter int DEPTH = 1024
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Branch_in,
  input  logic        MemRead_in,
  input  logic        MemWrite_in,
  input  logic        JRegControl_in,
  input  logic        RegWrite_in,
  input  logic [1:0]  MemReg_in,
  input  logic [1:0]  MuxLoad_in,
  input  logic        Zero_in,
  input  logic [31:0] ALUResult_in,
  input  logic [31:0] Rt_in,
  input  logic [31:0] Rs_in,
  input  logic [31:0] RtRd_in,
  input  logic [31:0] PCAdder_in,
  input  logic [31:0] PC2ndAdder_in,
  output logic        PCSrc_out,
  output logic [31:0] PCTarget_out,
  output logic        RegWrite_out,
  output logic [1:0]  MemReg_out,
  output logic [31:0] MemData_out,
  output logic [31:0] ALUResult_out,
  output logic [31:0] PCAdder_out,
`ifdef MEM_MISALIGN_TRAP_EN
  output logic        Misalign_out,
`endif
  output logic [4:0]  WriteReg_out
);

  localparam int AW = $clog2(DEPTH);

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] idx;
  logic [1:0]    lane;
  logic [31:0]   rd_word;
  logic [15:0]   rd_half;
  logic [7:0]    rd_byte;
  logic [31:0]   ld_data;
  logic [3:0]    wr_be;
  logic [31:0]   wr_data;
  logic          wr_en;
  logic          misalign;
  logic          unused_rtrd;

  assign idx         = ALUResult_in[AW+1:2];
  assign lane        = ALUResult_in[1:0];
  assign rd_word     = mem[idx];
  assign unused_rtrd = ^RtRd_in[31:5];

  // Redirect is combinational; a jump-register always wins over a taken branch.
  assign PCSrc_out    = ~Rst & ((Branch_in & Zero_in) | JRegControl_in);
  assign PCTarget_out = JRegControl_in ? Rs_in : PC2ndAdder_in;

`ifdef MEM_MISALIGN_TRAP_EN
  always_comb begin
    misalign = 1'b0;
    case (MuxLoad_in)
      2'b00:   misalign = |lane;
      2'b01:   misalign = lane[0];
      default: misalign = 1'b0;
    endcase
  end
`else
  assign misalign = 1'b0;
`endif

  // Load path: lane select and extension; unselected low address bits simply drop out.
  always_comb begin
    rd_half = lane[1] ? rd_word[31:16] : rd_word[15:0];
    rd_byte = rd_word[{lane, 3'b000} +: 8];
    ld_data = 32'h0;
    case (MuxLoad_in)
      2'b00:   ld_data = rd_word;
      2'b01:   ld_data = {{16{rd_half[15]}}, rd_half};
      2'b10:   ld_data = {{24{rd_byte[7]}}, rd_byte};
      default: ld_data = {24'h0, rd_byte};
    endcase
    if (!MemRead_in || misalign) ld_data = 32'h0;
  end

  // Store path: replicate the source across lanes and let byte enables pick the target.
  always_comb begin
    wr_be   = 4'b0000;
    wr_data = Rt_in;
    case (MuxLoad_in)
      2'b00: begin
        wr_be   = 4'b1111;
        wr_data = Rt_in;
      end
      2'b01: begin
        wr_be   = lane[1] ? 4'b1100 : 4'b0011;
        wr_data = {2{Rt_in[15:0]}};
      end
      default: begin
        wr_be   = 4'b0001 << lane;
        wr_data = {4{Rt_in[7:0]}};
      end
    endcase
  end

  assign wr_en = MemWrite_in & ~Rst & ~misalign;

  always_ff @(posedge Clk) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) mem[idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      RegWrite_out  <= 1'b0;
      MemReg_out    <= 2'b00;
      MemData_out   <= 32'h0;
      ALUResult_out <= 32'h0;
      PCAdder_out   <= 32'h0;
      WriteReg_out  <= 5'd0;
    end else begin
      RegWrite_out  <= RegWrite_in & ~(misalign & MemRead_in);
      MemReg_out    <= MemReg_in;
      MemData_out   <= ld_data;
      ALUResult_out <= ALUResult_in;
      PCAdder_out   <= PCAdder_in;
      WriteReg_out  <= RtRd_in[4:0];
    end
  end

`ifdef MEM_MISALIGN_TRAP_EN
  always_ff @(posedge Clk) begin
    if (Rst) Misalign_out <= 1'b0;
    else if (misalign && (MemRead_in || MemWrite_in)) Misalign_out <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage; expected load data is queued when a load is driven
// and popped when MemData_out is sampled one cycle later.
module tb_mem_stage;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        Branch_in, MemRead_in, MemWrite_in, JRegControl_in, RegWrite_in, Zero_in;
  logic [1:0]  MemReg_in, MuxLoad_in;
  logic [31:0] ALUResult_in, Rt_in, Rs_in, RtRd_in, PCAdder_in, PC2ndAdder_in;
  logic        PCSrc_out, RegWrite_out;
  logic [31:0] PCTarget_out, MemData_out, ALUResult_out, PCAdder_out;
  logic [1:0]  MemReg_out;
  logic [4:0]  WriteReg_out;
`ifdef MEM_MISALIGN_TRAP_EN
  logic        Misalign_out;
`endif

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] model [16];

  mem_stage #(.DEPTH(1024)) dut (
    .Clk(Clk), .Rst(Rst),
    .Branch_in(Branch_in), .MemRead_in(MemRead_in), .MemWrite_in(MemWrite_in),
    .JRegControl_in(JRegControl_in), .RegWrite_in(RegWrite_in), .MemReg_in(MemReg_in),
    .MuxLoad_in(MuxLoad_in), .Zero_in(Zero_in), .ALUResult_in(ALUResult_in),
    .Rt_in(Rt_in), .Rs_in(Rs_in), .RtRd_in(RtRd_in), .PCAdder_in(PCAdder_in),
    .PC2ndAdder_in(PC2ndAdder_in), .PCSrc_out(PCSrc_out), .PCTarget_out(PCTarget_out),
    .RegWrite_out(RegWrite_out), .MemReg_out(MemReg_out), .MemData_out(MemData_out),
    .ALUResult_out(ALUResult_out), .PCAdder_out(PCAdder_out),
`ifdef MEM_MISALIGN_TRAP_EN
    .Misalign_out(Misalign_out),
`endif
    .WriteReg_out(WriteReg_out)
  );

  // Clock / reset
  always #5 Clk = ~Clk;

  // Reference behaviour
  function automatic logic [31:0] load_model(input logic [31:0] w, input logic [1:0] a,
                                             input logic [1:0] sz);
    logic [15:0] h;
    logic [7:0]  b;
    h = a[1] ? w[31:16] : w[15:0];
    b = 8'(w >> (8 * a));
    case (sz)
      2'b00:   return w;
      2'b01:   return {{16{h[15]}}, h};
      2'b10:   return {{24{b[7]}}, b};
      default: return {24'h0, b};
    endcase
  endfunction

  function automatic logic [31:0] store_model(input logic [31:0] old, input logic [1:0] a,
                                              input logic [1:0] sz, input logic [31:0] d);
    logic [31:0] r;
    r = old;
    case (sz)
      2'b00:   r = d;
      2'b01:   if (a[1]) r[31:16] = d[15:0]; else r[15:0] = d[15:0];
      default: r[8*a +: 8] = d[7:0];
    endcase
    return r;
  endfunction

  // Driver tasks
  task automatic set_idle();
    Branch_in = 0; MemRead_in = 0; MemWrite_in = 0; JRegControl_in = 0; RegWrite_in = 0;
    Zero_in = 0; MemReg_in = 0; MuxLoad_in = 0; ALUResult_in = 0; Rt_in = 0; Rs_in = 0;
    RtRd_in = 0; PCAdder_in = 0; PC2ndAdder_in = 0;
  endtask

  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
    set_idle();
    MemWrite_in = 1; ALUResult_in = a; Rt_in = d; MuxLoad_in = sz;
    @(posedge Clk); #1;
  endtask

  task automatic do_load(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] rd);
    set_idle();
    MemRead_in = 1; RegWrite_in = 1; MemReg_in = 2'b01; ALUResult_in = a;
    MuxLoad_in = sz; RtRd_in = rd; PCAdder_in = a + 32'd4;
    @(posedge Clk); #1;
  endtask

  task automatic check_load(input string name);
    logic [31:0] e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_errors++;
      $display("FAIL %s: no expected entry queued, got %h", name, MemData_out);
    end else begin
      e = exp_q.pop_front();
      if (MemData_out !== e) begin
        n_errors++;
        $display("FAIL %s: MemData_out got %h expected %h", name, MemData_out, e);
      end
    end
  endtask

  // Tests
  task automatic test_reset();
    set_idle();
    Rst = 1; Branch_in = 1; Zero_in = 1; RegWrite_in = 1; RtRd_in = 5'd3;
    @(posedge Clk); @(posedge Clk); #1;
    n_checks++;
    if (PCSrc_out !== 1'b0) begin
      n_errors++; $display("FAIL reset_pcsrc: got %b expected 0", PCSrc_out);
    end
    n_checks++;
    if ({RegWrite_out, MemReg_out, MemData_out, ALUResult_out, PCAdder_out, WriteReg_out} !== '0) begin
      n_errors++;
      $display("FAIL reset_regs: got rw=%b mr=%b md=%h alu=%h pc=%h wr=%0d expected all 0",
               RegWrite_out, MemReg_out, MemData_out, ALUResult_out, PCAdder_out, WriteReg_out);
    end
`ifdef MEM_MISALIGN_TRAP_EN
    n_checks++;
    if (Misalign_out !== 1'b0) begin
      n_errors++; $display("FAIL reset_misalign: got %b expected 0", Misalign_out);
    end
`endif
    Rst = 0;
    set_idle();
  endtask

  task automatic test_word();
    do_store(32'h10, 32'hDEADBEEF, 2'b00);
    exp_q.push_back(32'hDEADBEEF);
    do_load(32'h10, 2'b00, 32'h0000_0047);
    check_load("word_load");
    n_checks++;
    if (WriteReg_out !== 5'd7 || RegWrite_out !== 1'b1 || MemReg_out !== 2'b01) begin
      n_errors++;
      $display("FAIL word_wb: got wr=%0d rw=%b mr=%b expected wr=7 rw=1 mr=01",
               WriteReg_out, RegWrite_out, MemReg_out);
    end
    n_checks++;
    if (ALUResult_out !== 32'h10 || PCAdder_out !== 32'h14) begin
      n_errors++;
      $display("FAIL word_pipe: got alu=%h pc=%h expected alu=10 pc=14", ALUResult_out, PCAdder_out);
    end
    // MemRead low returns zero even at a valid address
    set_idle(); ALUResult_in = 32'h10;
    @(posedge Clk); #1;
    n_checks++;
    if (MemData_out !== 32'h0) begin
      n_errors++; $display("FAIL noread: got %h expected 0", MemData_out);
    end
  endtask

  task automatic test_subword();
    do_store(32'h20, 32'h80FF7F01, 2'b00);
    exp_q.push_back(32'hFFFFFF80); do_load(32'h23, 2'b10, 1); check_load("lb_23");
    exp_q.push_back(32'h00000080); do_load(32'h23, 2'b11, 2); check_load("lbu_23");
    exp_q.push_back(32'h00007F01); do_load(32'h20, 2'b01, 3); check_load("lh_20");
    exp_q.push_back(32'hFFFF80FF); do_load(32'h22, 2'b01, 4); check_load("lh_22");
    exp_q.push_back(32'h0000007F); do_load(32'h21, 2'b10, 5); check_load("lb_21");
  endtask

  task automatic test_partial_store();
    do_store(32'h20, 32'h11223344, 2'b00);
    do_store(32'h21, 32'h000000AA, 2'b10);
    exp_q.push_back(32'h1122AA44); do_load(32'h20, 2'b00, 6); check_load("sb_21");
    do_store(32'h22, 32'h0000BEEF, 2'b01);
    exp_q.push_back(32'hBEEFAA44); do_load(32'h20, 2'b00, 6); check_load("sh_22");
    do_store(32'h20, 32'h00000055, 2'b11);
    exp_q.push_back(32'hBEEFAA55); do_load(32'h20, 2'b00, 6); check_load("sbu_20");
  endtask

  task automatic test_redirect();
    set_idle();
    Branch_in = 1; Zero_in = 1; PC2ndAdder_in = 32'h40; Rs_in = 32'h100; #1;
    n_checks++;
    if (PCSrc_out !== 1'b1 || PCTarget_out !== 32'h40) begin
      n_errors++; $display("FAIL br_taken: got src=%b tgt=%h expected 1 40", PCSrc_out, PCTarget_out);
    end
    Zero_in = 0; #1;
    n_checks++;
    if (PCSrc_out !== 1'b0) begin
      n_errors++; $display("FAIL br_not_taken: got %b expected 0", PCSrc_out);
    end
    Zero_in = 1; JRegControl_in = 1; #1;
    n_checks++;
    if (PCSrc_out !== 1'b1 || PCTarget_out !== 32'h100) begin
      n_errors++; $display("FAIL jr: got src=%b tgt=%h expected 1 100", PCSrc_out, PCTarget_out);
    end
    Branch_in = 0; Zero_in = 0; #1;
    n_checks++;
    if (PCSrc_out !== 1'b1 || PCTarget_out !== 32'h100) begin
      n_errors++; $display("FAIL jr_only: got src=%b tgt=%h expected 1 100", PCSrc_out, PCTarget_out);
    end
    @(posedge Clk); #1;
  endtask

  task automatic test_reset_mid();
    do_store(32'h30, 32'h77, 2'b00);
    set_idle();
    Rst = 1; MemWrite_in = 1; MemRead_in = 1; ALUResult_in = 32'h30; Rt_in = 32'h5;
    RegWrite_in = 1; MemReg_in = 2'b11; RtRd_in = 9; PCAdder_in = 32'h44;
    Branch_in = 1; Zero_in = 1; JRegControl_in = 1; #1;
    n_checks++;
    if (PCSrc_out !== 1'b0) begin
      n_errors++; $display("FAIL rst_mid_pcsrc: got %b expected 0", PCSrc_out);
    end
    @(posedge Clk); #1;
    n_checks++;
    if ({RegWrite_out, MemReg_out, MemData_out, ALUResult_out, PCAdder_out, WriteReg_out} !== '0) begin
      n_errors++;
      $display("FAIL rst_mid_regs: got rw=%b mr=%b md=%h alu=%h pc=%h wr=%0d expected all 0",
               RegWrite_out, MemReg_out, MemData_out, ALUResult_out, PCAdder_out, WriteReg_out);
    end
    Rst = 0;
    exp_q.push_back(32'h77); do_load(32'h30, 2'b00, 1); check_load("rst_mid_mem");
  endtask

  task automatic test_wrap();
    do_store(32'h0000_1050, 32'hCAFEF00D, 2'b00);
    exp_q.push_back(32'hCAFEF00D); do_load(32'h50, 2'b00, 2); check_load("wrap");
  endtask

  task automatic test_misalign();
    do_store(32'h31, 32'h12345678, 2'b00);
`ifdef MEM_MISALIGN_TRAP_EN
    n_checks++;
    if (Misalign_out !== 1'b1) begin
      n_errors++; $display("FAIL mis_flag: got %b expected 1", Misalign_out);
    end
    exp_q.push_back(32'h77); do_load(32'h30, 2'b00, 1); check_load("mis_nowrite");
    exp_q.push_back(32'h0); do_load(32'h33, 2'b01, 8); check_load("mis_load");
    n_checks++;
    if (RegWrite_out !== 1'b0) begin
      n_errors++; $display("FAIL mis_regwrite: got %b expected 0", RegWrite_out);
    end
    set_idle(); repeat (3) @(posedge Clk); #1;
    n_checks++;
    if (Misalign_out !== 1'b1) begin
      n_errors++; $display("FAIL mis_sticky: got %b expected 1", Misalign_out);
    end
    Rst = 1; @(posedge Clk); #1; Rst = 0;
    n_checks++;
    if (Misalign_out !== 1'b0) begin
      n_errors++; $display("FAIL mis_clear: got %b expected 0", Misalign_out);
    end
`else
    exp_q.push_back(32'h12345678); do_load(32'h30, 2'b00, 1); check_load("mis_word_aligned");
    exp_q.push_back(32'h00001234); do_load(32'h33, 2'b01, 8); check_load("mis_half_aligned");
    n_checks++;
    if (RegWrite_out !== 1'b1) begin
      n_errors++; $display("FAIL mis_regwrite: got %b expected 1", RegWrite_out);
    end
`endif
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, d;
    logic [1:0]  sz, off;
    int          w;
    for (int i = 0; i < 16; i++) begin
      d = $urandom;
      model[i] = d;
      do_store(32'h200 + 32'(i * 4), d, 2'b00);
    end
    for (int i = 0; i < 40; i++) begin
      w  = $urandom_range(0, 15);
      sz = 2'($urandom_range(0, 3));
      off = (sz == 2'b00) ? 2'b00 :
            (sz == 2'b01) ? {1'($urandom_range(0, 1)), 1'b0} : 2'($urandom_range(0, 3));
      a = 32'h200 + 32'(w * 4) + {30'h0, off};
      if ($urandom_range(0, 1) == 1) begin
        d = $urandom;
        model[w] = store_model(model[w], off, sz, d);
        do_store(a, d, sz);
      end else begin
        exp_q.push_back(load_model(model[w], off, sz));
        do_load(a, sz, 32'(w));
        check_load("b2b_load");
      end
    end
  endtask

  initial begin
    set_idle();
    Rst = 1;
    test_reset();
    test_word();
    test_subword();
    test_partial_store();
    test_redirect();
    test_reset_mid();
    test_wrap();
    test_misalign();
    test_back_to_back();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++; $display("FAIL queue_drain: %0d entries left expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
